mux_sel_sequencer: RTL and testbench
====================================

// Module: mux_sel_sequencer
// PURPOSE
//   Upstream select generator for the 4:1 channel mux. Scans the enabled channels in
//   round-robin order and drives the mux sel. Waits a settle interval after each
//   select change, then holds the channel for a programmable dwell time. Pulses a
//   strobe at the end of each dwell so the consumer samples mux output y.
// PARAMETERS
//   DW_W        8   width of dwell input (dwell cycles = dwell+1)
//   SETTLE_CYC  2   cycles sel_valid stays low after sel changes (0 = none)
// PORTS
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   start      in   1     begin scanning (level sampled each clk; ignored while busy)
//   stop       in   1     abort scan; highest priority
//   ch_en      in   4     channel enable mask, bit i = channel i
//   dwell      in   DW_W  dwell length per channel, minus one
//   oneshot    in   1     single-pass mode request (see CONFIGURATION)
//   sel        out  2     mux select, registered
//   sel_valid  out  1     sel settled; mux output y is usable
//   ch_strobe  out  1     1-cycle pulse on the last dwell cycle of a channel
//   busy       out  1     scan in progress
//   done       out  1     1-cycle pulse when a one-shot pass completes
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//     - Outputs: sel=0, sel_valid=0, ch_strobe=0, busy=0, done=0.
//     - Internal: state=IDLE, counters=0.
//   - States: IDLE, SETTLE, DWELL. All outputs are registered.
//   - IDLE:
//     - start=1 with ch_en!=0: sel<=lowest enabled index and busy<=1.
//       Go to SETTLE, or to DWELL if SETTLE_CYC=0.
//     - start with ch_en==0: ignored.
//   - SETTLE:
//     - sel_valid=0 for exactly SETTLE_CYC cycles, then go to DWELL.
//   - DWELL:
//     - dwell is captured on entry.
//     - sel_valid=1 for dwell+1 cycles. ch_strobe=1 on the final cycle only.
//   - Advance at the end of DWELL:
//     - ch_en is re-sampled.
//     - Next channel = next enabled index above sel, wrapping 3->0.
//     - Next == current (single channel enabled): re-enter DWELL directly.
//       No settle, and sel_valid stays 1.
//     - Otherwise update sel and go to SETTLE.
//     - ch_en==0 at advance: go to IDLE, busy<=0, sel holds its value.
//   - Latency: start is sampled at edge E0. busy=1 and sel are valid after E0.
//     sel_valid first rises after edge E0+SETTLE_CYC.
//   - stop=1 from any state: next cycle state=IDLE, busy=0, sel_valid=0, ch_strobe=0,
//     and sel holds. stop and start in the same cycle: stop wins.
//   - start while busy: ignored; the scan order is unaffected.
//   - dwell=0: 1-cycle dwell, and ch_strobe coincides with the first sel_valid cycle.
//   - Mid-scan reset: everything returns to reset values immediately (async).
// CONFIGURATION
//   - Macro SEQ_ONESHOT_EN defined:
//     - oneshot is sampled with start.
//     - If it was 1, the pass ends at the advance that would wrap (next index <= sel).
//       State goes to IDLE, busy<=0, and done=1 for one cycle after that ch_strobe.
//     - Otherwise scanning is continuous.
//   - Macro SEQ_ONESHOT_EN undefined: oneshot is ignored, scanning is always
//     continuous, and done is tied 0.
// TESTING
//   1. Continuous scan: ch_en=4'b1111, dwell=3, SETTLE_CYC=2, pulse start.
//      -> sel sequence 0,1,2,3,0,..., each with 2 invalid and 4 valid cycles.
//      -> ch_strobe pulses every 6 cycles.
//   2. Mask skip: ch_en=4'b1010 -> sel alternates 1,3,1,...
//      Set ch_en=4'b0000 mid-dwell -> after the current strobe, busy=0 and sel holds 3 or 1.
//   3. Single channel: ch_en=4'b0100, dwell=0.
//      -> sel=2 constant, sel_valid stays 1 after the settle, ch_strobe=1 every cycle.
//   4. Stop priority: start and stop both asserted in IDLE -> remains IDLE.
//      Stop during SETTLE of ch1 -> next cycle busy=0, sel_valid=0, sel=1.
//   5. One-shot (SEQ_ONESHOT_EN): ch_en=4'b0111, oneshot=1, start.
//      -> strobes on ch 0,1,2, then done=1 for one cycle, busy=0.
//      Without the macro: scanning continues and done stays 0.
//   6. Reset mid-dwell: drop rst_n asynchronously.
//      -> all outputs read 0 before the next clk edge. start after release behaves as test 1.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
//   Round-robin select generator for a 4:1 channel mux. After each change of
//   sel it holds sel_valid low for SETTLE_CYC cycles. It then dwells on the
//   channel for dwell+1 cycles and pulses ch_strobe on the last dwell cycle.
//   All outputs are registered. stop has priority over everything else.
//
//   Optional feature macro: SEQ_ONESHOT_EN
//     defined   - oneshot is sampled with start. A one-shot pass ends at the
//                 advance that would wrap, and done pulses for one cycle.
//     undefined - scanning is always continuous and done stays 0.
module mux_sel_sequencer #(
  parameter int DW_W       = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic [3:0]      ch_en,
  input  logic [DW_W-1:0] dwell,
  input  logic            oneshot,
  output logic [1:0]      sel,
  output logic            sel_valid,
  output logic            ch_strobe,
  output logic            busy,
  output logic            done
);

  localparam int SC_W        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int SETTLE_LAST = (SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2
  } state_t;

  // Searches cur+1, cur+2, cur+3, then cur itself, wrapping 3->0.
  // Returns {found, index}. Passing cur=3 yields the lowest enabled index.
  function automatic logic [2:0] next_enabled(input logic [3:0] en, input logic [1:0] cur);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (en[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t            state_r, state_s;
  logic [1:0]        sel_r, sel_s;
  logic              sel_valid_r, sel_valid_s;
  logic              ch_strobe_r, ch_strobe_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [SC_W-1:0]   settle_cnt_r, settle_cnt_s;
  logic [DW_W-1:0]   dwell_cnt_r, dwell_cnt_s;

  logic [2:0]        first_s;
  logic [2:0]        adv_s;
  logic              adv_found_s;
  logic [1:0]        adv_idx_s;
  logic              adv_same_s;
  logic              start_ok_s;
  logic              settle_end_s;
  logic              dwell_end_s;
  logic              dwell_zero_s;
  logic              pass_end_s;

  assign first_s      = next_enabled(ch_en, 2'd3);
  assign adv_s        = next_enabled(ch_en, sel_r);
  assign adv_found_s  = adv_s[2];
  assign adv_idx_s    = adv_s[1:0];
  assign adv_same_s   = (adv_idx_s == sel_r);
  assign start_ok_s   = start && (ch_en != 4'b0000) && (state_r == ST_IDLE);
  assign settle_end_s = (settle_cnt_r == SC_W'(SETTLE_LAST));
  assign dwell_end_s  = (dwell_cnt_r == {DW_W{1'b0}});
  assign dwell_zero_s = (dwell == {DW_W{1'b0}});

`ifdef SEQ_ONESHOT_EN
  logic oneshot_r;

  // Capture the one-shot request alongside an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oneshot_r <= 1'b0;
    end else if (start_ok_s && !stop) begin
      oneshot_r <= oneshot;
    end else begin
      oneshot_r <= oneshot_r;
    end
  end

  // The pass ends at an advance that would wrap back to or below the current channel.
  assign pass_end_s = oneshot_r && (adv_idx_s <= sel_r);
`else
  logic oneshot_unused_s;
  assign oneshot_unused_s = oneshot;
  assign pass_end_s       = 1'b0;
`endif

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    if (stop) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            state_s = (SETTLE_CYC == 0) ? ST_DWELL : ST_SETTLE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (settle_end_s) begin
            state_s = ST_DWELL;
          end else begin
            state_s = ST_SETTLE;
          end
        end
        ST_DWELL: begin
          if (!dwell_end_s) begin
            state_s = ST_DWELL;
          end else if (!adv_found_s || pass_end_s) begin
            state_s = ST_IDLE;
          end else if (adv_same_s) begin
            state_s = ST_DWELL;
          end else begin
            state_s = (SETTLE_CYC == 0) ? ST_DWELL : ST_SETTLE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Next values of the registered outputs and phase counters.
  always_comb begin
    sel_s        = sel_r;
    busy_s       = busy_r;
    sel_valid_s  = 1'b0;
    ch_strobe_s  = 1'b0;
    done_s       = 1'b0;
    settle_cnt_s = settle_cnt_r;
    dwell_cnt_s  = dwell_cnt_r;
    if (stop) begin
      busy_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            sel_s        = first_s[1:0];
            busy_s       = 1'b1;
            settle_cnt_s = {SC_W{1'b0}};
            if (SETTLE_CYC == 0) begin
              dwell_cnt_s = dwell;
              sel_valid_s = 1'b1;
              ch_strobe_s = dwell_zero_s;
            end else begin
              dwell_cnt_s = dwell_cnt_r;
            end
          end else begin
            busy_s = 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_end_s) begin
            settle_cnt_s = {SC_W{1'b0}};
            dwell_cnt_s  = dwell;
            sel_valid_s  = 1'b1;
            ch_strobe_s  = dwell_zero_s;
          end else begin
            settle_cnt_s = settle_cnt_r + SC_W'(1);
          end
        end
        ST_DWELL: begin
          if (!dwell_end_s) begin
            dwell_cnt_s = dwell_cnt_r - DW_W'(1);
            sel_valid_s = 1'b1;
            ch_strobe_s = (dwell_cnt_r == DW_W'(1));
          end else if (!adv_found_s) begin
            busy_s = 1'b0;
          end else if (pass_end_s) begin
            busy_s = 1'b0;
            done_s = 1'b1;
          end else if (adv_same_s) begin
            // Sole enabled channel: stay valid and start a fresh dwell.
            dwell_cnt_s = dwell;
            sel_valid_s = 1'b1;
            ch_strobe_s = dwell_zero_s;
          end else begin
            sel_s = adv_idx_s;
            if (SETTLE_CYC == 0) begin
              dwell_cnt_s = dwell;
              sel_valid_s = 1'b1;
              ch_strobe_s = dwell_zero_s;
            end else begin
              settle_cnt_s = {SC_W{1'b0}};
            end
          end
        end
        default: begin
          busy_s = 1'b0;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      sel_r        <= 2'd0;
      sel_valid_r  <= 1'b0;
      ch_strobe_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      settle_cnt_r <= {SC_W{1'b0}};
      dwell_cnt_r  <= {DW_W{1'b0}};
    end else begin
      state_r      <= state_s;
      sel_r        <= sel_s;
      sel_valid_r  <= sel_valid_s;
      ch_strobe_r  <= ch_strobe_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      settle_cnt_r <= settle_cnt_s;
      dwell_cnt_r  <= dwell_cnt_s;
    end
  end

  assign sel       = sel_r;
  assign sel_valid = sel_valid_r;
  assign ch_strobe = ch_strobe_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Testbench for mux_sel_sequencer: directed scenarios followed by random
// stimulus. Checking is against a queue-based schedule model. Honours
// SEQ_ONESHOT_EN in the same way as the design.
module tb_mux_sel_sequencer;

  localparam int DW_W       = 8;
  localparam int SETTLE_CYC = 2;
`ifdef SEQ_ONESHOT_EN
  localparam bit ONESHOT_BUILD = 1'b1;
`else
  localparam bit ONESHOT_BUILD = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            stop;
  logic [3:0]      ch_en;
  logic [DW_W-1:0] dwell;
  logic            oneshot;
  logic [1:0]      sel;
  logic            sel_valid;
  logic            ch_strobe;
  logic            busy;
  logic            done;

  mux_sel_sequencer #(.DW_W(DW_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .ch_en     (ch_en),
    .dwell     (dwell),
    .oneshot   (oneshot),
    .sel       (sel),
    .sel_valid (sel_valid),
    .ch_strobe (ch_strobe),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one slot per future cycle of the current phase.
  typedef struct packed {
    logic v;
    logic s;
  } slot_t;

  slot_t q[$];
  slot_t last_slot;
  int    m_sel;
  bit    m_busy;
  bit    m_oneshot;
  bit    e_valid;
  bit    e_strobe;
  bit    e_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("sel",       32'(sel),       32'(m_sel));
    chk("sel_valid", 32'(sel_valid), 32'(e_valid));
    chk("ch_strobe", 32'(ch_strobe), 32'(e_strobe));
    chk("busy",      32'(busy),      32'(m_busy));
    chk("done",      32'(done),      32'(e_done));
  endtask

  // First enabled channel after cur in round-robin order (cur itself last); -1 if none.
  function automatic int next_en(input logic [3:0] en, input int cur);
    for (int k = 1; k <= 4; k++) begin
      if (en[(cur + k) % 4]) return (cur + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    last_slot = '0;
    m_sel     = 0;
    m_busy    = 1'b0;
    m_oneshot = 1'b0;
    e_valid   = 1'b0;
    e_strobe  = 1'b0;
    e_done    = 1'b0;
  endtask

  task automatic push_dwell();
    for (int i = 0; i <= int'(dwell); i++) begin
      q.push_back({1'b1, (i == int'(dwell))});
    end
  endtask

  task automatic push_new_channel();
    if (SETTLE_CYC > 0) begin
      for (int i = 0; i < SETTLE_CYC; i++) q.push_back(2'b00);
    end else begin
      push_dwell();
    end
  endtask

  task automatic pop_out();
    last_slot = q.pop_front();
    e_valid   = last_slot.v;
    e_strobe  = last_slot.s;
  endtask

  task automatic go_idle();
    q.delete();
    m_busy   = 1'b0;
    e_valid  = 1'b0;
    e_strobe = 1'b0;
  endtask

  // Evaluate the inputs seen at a rising edge; yields the outputs for the following cycle.
  task automatic model_step();
    int nxt;
    e_done = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (stop) begin
      go_idle();
      return;
    end
    if (!m_busy) begin
      e_valid  = 1'b0;
      e_strobe = 1'b0;
      if (start && ch_en != 4'b0000) begin
        m_busy    = 1'b1;
        m_sel     = next_en(ch_en, 3);
        m_oneshot = oneshot;
        push_new_channel();
        pop_out();
      end
      return;
    end
    if (q.size() == 0) begin
      if (!last_slot.s) begin
        push_dwell();
      end else begin
        nxt = next_en(ch_en, m_sel);
        if (nxt < 0) begin
          go_idle();
          return;
        end
        if (ONESHOT_BUILD && m_oneshot && nxt <= m_sel) begin
          go_idle();
          e_done = 1'b1;
          return;
        end
        if (nxt == m_sel) begin
          push_dwell();
        end else begin
          m_sel = nxt;
          push_new_channel();
        end
      end
    end
    pop_out();
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic drive(input bit st, input bit sp, input logic [3:0] en,
                       input int dw, input bit os);
    start   = st;
    stop    = sp;
    ch_en   = en;
    dwell   = DW_W'(dw);
    oneshot = os;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 4'b0000, 0, 0);
    model_reset();
    run_n(2);
    rst_n = 1'b1;
    run_n(1);

    // Continuous scan over all channels.
    drive(1, 0, 4'b1111, 3, 0); run_n(1);
    drive(0, 0, 4'b1111, 3, 0); run_n(30);
    drive(0, 1, 4'b1111, 3, 0); run_n(2);

    // Mask skip, then disable all channels mid-scan.
    drive(1, 0, 4'b1010, 2, 0); run_n(1);
    drive(0, 0, 4'b1010, 2, 0); run_n(17);
    drive(0, 0, 4'b0000, 2, 0); run_n(10);

    // Single channel with one-cycle dwell; start while busy is ignored.
    drive(1, 0, 4'b0100, 0, 0); run_n(1);
    drive(0, 0, 4'b0100, 0, 0); run_n(6);
    drive(1, 0, 4'b1111, 0, 0); run_n(6);
    drive(0, 1, 4'b0100, 0, 0); run_n(2);

    // stop beats start in IDLE; stop during the settle of channel 1.
    drive(1, 1, 4'b1111, 2, 0); run_n(3);
    drive(1, 0, 4'b0010, 2, 0); run_n(1);
    drive(0, 1, 4'b0010, 2, 0); run_n(2);
    drive(0, 0, 4'b0010, 2, 0); run_n(2);

    // One-shot request over channels 0..2.
    drive(1, 0, 4'b0111, 1, 1); run_n(1);
    drive(0, 0, 4'b0111, 1, 0); run_n(25);
    drive(0, 1, 4'b0111, 1, 0); run_n(2);

    // Asynchronous reset in the middle of a dwell.
    drive(1, 0, 4'b1111, 3, 0); run_n(1);
    drive(0, 0, 4'b1111, 3, 0); run_n(8);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    run_n(2);
    rst_n = 1'b1;
    drive(1, 0, 4'b1111, 3, 0); run_n(1);
    drive(0, 0, 4'b1111, 3, 0); run_n(20);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 49) == 0);
      oneshot = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) ch_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)  dwell = DW_W'($urandom_range(0, 4));
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
